// File: rtl/pzbcm_round_robin_grant_if.sv
// Request/grant bundle between requesters and the round-robin grant stage.
// The arbiter uses the slave view; the requester side uses the master view.
interface pzbcm_round_robin_grant_if #(
  parameter int N = 4
);
  localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1;

  logic [N-1:0]            i_request;
  logic                    i_release;
  logic                    o_grant_valid;
  logic [N-1:0]            o_grant;
  logic [BINARY_WIDTH-1:0] o_grant_index;

  modport slave (
    input  i_request,
    input  i_release,
    output o_grant_valid,
    output o_grant,
    output o_grant_index
  );

  modport master (
    output i_request,
    output i_release,
    input  o_grant_valid,
    input  o_grant,
    input  o_grant_index
  );
endinterface

// File: rtl/pzbcm_round_robin_grant.sv
// Round-robin arbiter that holds a registered onehot grant and its binary index
// until the owner releases; the priority pointer advances only on release.
module pzbcm_round_robin_grant #(
  parameter int N = 4
) (
  input logic                        i_clk,
  input logic                        i_rst,
  pzbcm_round_robin_grant_if.slave   bus
);
  localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef logic [BINARY_WIDTH-1:0] index_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  index_t         index_q, index_d;
  index_t         ptr_q, ptr_d;
  index_t         release_ptr;
  index_t         arb_ptr;
  logic           win_found;
  index_t         win_index;
  logic [N-1:0]   win_onehot;

  // Scan r starting at p and wrapping modulo N; returns {found, index}.
  function automatic logic [BINARY_WIDTH:0] find_winner(
    input logic [N-1:0] r,
    input index_t       p
  );
    logic   found;
    index_t idx;
    int     k;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      k = int'(p) + off;
      if (k >= N) begin
        k = k - N;
      end
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = index_t'(k);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    release_ptr = (index_q == index_t'(N - 1)) ? '0 : index_q + 1'b1;
    // In GRANT the only arbitration that matters is the one on release,
    // which already uses the advanced pointer.
    arb_ptr = (state_q == GRANT) ? release_ptr : ptr_q;
    {win_found, win_index} = find_winner(bus.i_request, arb_ptr);
    win_onehot = '0;
    win_onehot[win_index] = win_found;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = win_onehot;
          index_d = win_index;
        end
      end
      GRANT: begin
        if (bus.i_release) begin
          ptr_d = release_ptr;
          if (win_found) begin
            grant_d = win_onehot;
            index_d = win_index;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            index_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      index_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_grant_valid = (state_q == GRANT);
  assign bus.o_grant       = grant_q;
  assign bus.o_grant_index = index_q;

  a_onehot_iff_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.o_grant_valid ? $onehot(bus.o_grant) : (bus.o_grant == '0));

  a_index_matches: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.o_grant_valid |-> bus.o_grant[bus.o_grant_index]);

  a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (bus.o_grant_valid && !bus.i_release) |=>
      (bus.o_grant_valid && $stable(bus.o_grant) && $stable(bus.o_grant_index)));
endmodule

// File: tb/tb_pzbcm_round_robin_grant.sv
// Scoreboard bench for the round-robin grant stage with N=4, N=3 and N=5
// instances sharing one clock and reset.
module tb_pzbcm_round_robin_grant;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pzbcm_round_robin_grant_if #(.N(4)) if4 ();
  pzbcm_round_robin_grant_if #(.N(3)) if3 ();
  pzbcm_round_robin_grant_if #(.N(5)) if5 ();

  pzbcm_round_robin_grant #(.N(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4));
  pzbcm_round_robin_grant #(.N(3)) dut3 (.i_clk(clk), .i_rst(rst), .bus(if3));
  pzbcm_round_robin_grant #(.N(5)) dut5 (.i_clk(clk), .i_rst(rst), .bus(if5));

  typedef struct {
    int         sel;
    logic       v;
    logic [7:0] g;
    logic [2:0] i;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   c_last   = 4;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected instance and queue the
  // registered response expected right after the next rising edge.
  task automatic cycle(input int sel, input logic [7:0] req, input logic rel,
                       input logic ev, input logic [2:0] ei, input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    if4.i_request = (sel == 0) ? req[3:0] : 4'd0;
    if3.i_request = (sel == 1) ? req[2:0] : 3'd0;
    if5.i_request = (sel == 2) ? req[4:0] : 5'd0;
    if4.i_release = (sel == 0) ? rel : 1'b0;
    if3.i_release = (sel == 1) ? rel : 1'b0;
    if5.i_release = (sel == 2) ? rel : 1'b0;
    e.sel = sel;
    e.v   = ev;
    e.g   = ev ? (8'd1 << ei) : 8'd0;
    e.i   = ev ? ei : 3'd0;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents fresh registered outputs.
  always @(posedge clk) begin
    exp_t       e;
    logic       a_v;
    logic [7:0] a_g;
    logic [2:0] a_i;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       begin a_v = if4.o_grant_valid; a_g = {4'd0, if4.o_grant}; a_i = {1'b0, if4.o_grant_index}; end
        1:       begin a_v = if3.o_grant_valid; a_g = {5'd0, if3.o_grant}; a_i = {1'b0, if3.o_grant_index}; end
        default: begin a_v = if5.o_grant_valid; a_g = {3'd0, if5.o_grant}; a_i = if5.o_grant_index; end
      endcase
      $display("txn dut%0d %s: valid=%0d grant=%b index=%0d", e.sel, e.tag, a_v, a_g, a_i);
      chk({e.tag, "_valid"}, int'(a_v), int'(e.v));
      chk({e.tag, "_grant"}, int'(a_g), int'(e.g));
      chk({e.tag, "_index"}, int'(a_i), int'(e.i));
      if (e.sel == 1) begin
        chk("n3_index_range", int'(a_i <= 3'd2), 1);
      end
      if (e.sel == 2 && a_v && int'(a_i) != c_last) begin
        chk("n5_order", int'(a_i), (c_last + 1) % 5);
        c_last = int'(a_i);
      end
    end
  end

  // Reference arbitration for the random phases.
  bit m_valid;
  int m_idx;
  int m_ptr;

  function automatic int ref_winner(input int n, input logic [7:0] r, input int p);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, input logic [7:0] r, input logic rel);
    int w;
    if (!m_valid) begin
      w = ref_winner(n, r, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_idx   = w;
      end
    end else if (rel) begin
      m_ptr = (m_idx + 1) % n;
      w = ref_winner(n, r, m_ptr);
      if (w >= 0) begin
        m_idx = w;
      end else begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end
  endtask

  initial begin
    logic [7:0] req;
    logic       rel;
    int         guard;
    if4.i_request = '0; if4.i_release = 1'b0;
    if3.i_request = '0; if3.i_release = 1'b0;
    if5.i_request = '0; if5.i_release = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid4", int'(if4.o_grant_valid), 0);
    chk("rst_grant4", int'(if4.o_grant), 0);
    chk("rst_valid3", int'(if3.o_grant_valid), 0);
    chk("rst_valid5", int'(if5.o_grant_valid), 0);

    // N=4 directed sequence
    cycle(0, 8'b1111, 0, 1, 0, "grant0");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(if4.o_grant_valid), 0);
    chk("midrst_grant", int'(if4.o_grant), 0);
    chk("midrst_index", int'(if4.o_grant_index), 0);
    cycle(0, 8'b1010, 0, 1, 1, "post_rst");
    repeat (5) cycle(0, 8'b1000, 0, 1, 1, "hold");
    cycle(0, 8'b1010, 1, 1, 3, "rotate");
    cycle(0, 8'b0000, 0, 1, 3, "hold3");
    cycle(0, 8'b1001, 1, 1, 0, "wrap");
    cycle(0, 8'b0000, 1, 0, 0, "rel_idle");
    cycle(0, 8'b0000, 0, 0, 0, "idle");
    cycle(0, 8'b0000, 1, 0, 0, "rel_ignored");
    cycle(0, 8'b0011, 0, 1, 1, "ptr_kept");
    cycle(0, 8'b0011, 1, 1, 0, "rel_lowest");
    cycle(0, 8'b0001, 1, 1, 0, "regrant_self");
    cycle(0, 8'b0000, 1, 0, 0, "drain4");

    // N=3 directed, then random against the reference
    cycle(1, 8'b100, 0, 1, 2, "n3_grant2");
    cycle(1, 8'b111, 1, 1, 0, "n3_wrap");
    cycle(1, 8'b000, 1, 0, 0, "n3_drain");
    m_valid = 1'b0; m_idx = 0; m_ptr = 1;
    repeat (1000) begin
      req = 8'($urandom_range(0, 7));
      rel = 1'($urandom_range(0, 1));
      model_step(3, req, rel);
      cycle(1, req, rel, m_valid, 3'(m_idx), "n3_rand");
    end

    // N=5 fairness: everyone requests, releases at random times
    m_valid = 1'b0; m_idx = 0; m_ptr = 0;
    repeat (300) begin
      req = 8'b0001_1111;
      rel = ($urandom_range(0, 3) == 0);
      model_step(5, req, rel);
      cycle(2, req, rel, m_valid, 3'(m_idx), "n5_fair");
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      chk("scoreboard_drain", q.size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pzbcm_round_robin_grant.md
Name: pzbcm_round_robin_grant

Overview:
- Sequential arbitration stage that sits directly upstream of the onehot/binary conversion utility.
- Takes an N-bit request vector and selects one winner with rotating (round-robin) priority.
- Holds a registered onehot grant stable until the owner releases it.
- Presents the winner both as a onehot vector and as a binary index, for downstream mux select and for tagging.

Parameters:
- N, 4, number of requesters; legal range N >= 1.
- BINARY_WIDTH, derived (not overridable): (N >= 2) ? $clog2(N) : 1; width of the index and of the priority pointer.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_request  input  N  request vector; bit k = requester k wants ownership.
- i_release  input  1  owner ends its tenure this cycle; ignored when o_grant_valid=0.
- o_grant_valid  output  1  a grant is currently held.
- o_grant  output  N  registered onehot grant; all-zero when o_grant_valid=0.
- o_grant_index  output  BINARY_WIDTH  registered binary index of the granted requester; 0 when no grant.

Behaviour:
- Reset: async assert clears o_grant_valid=0, o_grant='0, o_grant_index=0, priority pointer ptr=0, state=IDLE. It takes effect immediately, including mid-grant. The first arbitration after deassert uses ptr=0.
- Winner function (combinational, internal), given vector r and pointer p:
  - Choose the first set bit of r scanning k = p, p+1, ..., N-1, 0, ..., p-1.
  - Exactly one bit or none is selected; never multi-hot.
- States:
  - IDLE: if |i_request, latch winner(i_request, ptr) into o_grant/o_grant_index, set o_grant_valid=1, go to GRANT. Otherwise stay in IDLE with outputs zero.
  - GRANT: o_grant, o_grant_index and o_grant_valid hold stable every cycle until i_release=1. Changes to i_request while in GRANT are ignored, including the owner dropping its request.
  - GRANT with i_release=1:
    - Set ptr_next = (o_grant_index == N-1) ? 0 : o_grant_index+1. ptr is updated to ptr_next on this edge.
    - If |i_request in the release cycle: latch winner(i_request, ptr_next) and stay in GRANT. The new grant is visible the next cycle with no idle bubble.
    - Otherwise: clear outputs and go to IDLE.
- Latency: exactly 1 cycle from request sampled (IDLE) or release sampled (GRANT) to the new registered grant.
- Fairness:
  - The releasing requester becomes lowest priority in the following arbitration, even if it still requests in the release cycle.
  - A continuously requesting requester is granted within N grants.
- Pointer wrap: ptr is modulo N, not modulo 2^BINARY_WIDTH. Values >= N are never reached (matters for N=3, 5, ...).
- ptr changes only on release. It does not change in IDLE or on a fresh IDLE->GRANT transition.
- N=1:
  - BINARY_WIDTH=1, o_grant_index constant 0, ptr constant 0.
  - Release with i_request=1 regrants requester 0 back-to-back.
- Invariants, checked by assertions:
  - o_grant is onehot iff o_grant_valid=1, and '0 otherwise.
  - o_grant[o_grant_index]=1 whenever valid.
  - Outputs are stable while valid && !i_release.
- Outputs are driven only from flops; there is no combinational path from i_request/i_release to any output.

Test Plan:
- Reset: assert i_rst mid-cycle with i_request=4'b1111 -> all outputs 0 immediately. After deassert with i_request=4'b1010, o_grant=4'b0010 and o_grant_index=1 one cycle later.
- Hold: while holding grant idx1, change i_request to 4'b1000 for 5 cycles with i_release=0 -> o_grant stays 4'b0010 and o_grant_index=1.
- Back-to-back rotation, N=4: holding idx1, pulse i_release with i_request=4'b1010 -> next cycle o_grant=4'b1000, idx3, no valid gap (ptr was 2).
- Wrap, N=4: holding idx3, release with i_request=4'b1001 -> o_grant=4'b0001, idx0. Then release with i_request=4'b0000 -> o_grant_valid=0 next cycle, stays in IDLE.
- Non-power-of-2, N=3: holding idx2, release with i_request=3'b111 -> idx0. Confirm the index never exceeds 2 over 1000 random cycles.
- Fairness, random: N=5, all requesters always requesting, random release timing -> grant order 0,1,2,3,4,0,... Any requester held continuously is granted within 5 grants.
